// File: rtl/remote_cmd_seq.sv
// remote_cmd_seq: queues {cmd, data} requests for RemoteComm, issues them one
// at a time, waits for the quad's response byte and retires on 8'hA5.
// Requests that keep failing are retried a bounded number of times, then
// dropped with an error code. EMER_LAND flushes everything queued behind the
// in-flight head and takes the next slot.
module remote_cmd_seq #(
  parameter int RESP_TMO  = 1_000_000,
  parameter int MAX_RETRY = 3,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_vld,
  input  logic [7:0]               req_cmd,
  input  logic [15:0]              req_data,
  output logic                     req_rdy,
  output logic [7:0]               cmd,
  output logic [15:0]              data,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     clr_resp_rdy,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(RESP_TMO + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] TMO_LIMIT   = TW'(RESP_TMO);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [CW-1:0] FIFO_FULL   = CW'(DEPTH);
  localparam logic [7:0]    EMER_LAND   = 8'h07;
  localparam logic [7:0]    ACK_BYTE    = 8'hA5;
  localparam logic [1:0]    CAUSE_TMO   = 2'b01;
  localparam logic [1:0]    CAUSE_BAD   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    LATCH_RESP,
    CHECK,
    RETRY
  } state_t;

  state_t state, state_n;

  logic [7:0]    cmd_mem  [DEPTH];
  logic [15:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] rd_ptr_n, wr_ptr_n, wr_addr;
  logic [CW-1:0] fifo_cnt_n;
  logic [AW-1:0] rd_ptr_inc;

  logic          is_emer, full, push, pop;
  logic [7:0]    head_nxt_cmd;
  logic [15:0]   head_nxt_data;
  logic          load_head;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, tmo_clr, tmo_run;
  logic [RW-1:0] retry_cnt;
  logic          retry_inc, retry_clr;
  logic [7:0]    resp_q;
  logic          resp_latch;
  logic [1:0]    cause, cause_nxt;
  logic          cause_set;

  assign is_emer    = (req_cmd == EMER_LAND);
  assign full       = (fifo_cnt == FIFO_FULL);
  assign req_rdy    = !full || is_emer;
  assign push       = req_vld && req_rdy;
  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign tmo_hit    = (tmo_cnt >= TMO_LIMIT);
  assign busy       = (state != IDLE) || (fifo_cnt != '0);

  // FIFO pointer/count update, including the EMER_LAND flush that keeps only the head
  always_comb begin
    wr_addr    = wr_ptr;
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;
    fifo_cnt_n = fifo_cnt;
    if (push && is_emer && (fifo_cnt != '0)) begin
      wr_addr = rd_ptr_inc;
      if (pop) begin
        rd_ptr_n   = rd_ptr_inc;
        wr_ptr_n   = rd_ptr + AW'(2);
        fifo_cnt_n = CW'(1);
      end else begin
        wr_ptr_n   = rd_ptr + AW'(2);
        fifo_cnt_n = CW'(2);
      end
    end else begin
      if (push) wr_ptr_n = wr_ptr + AW'(1);
      if (pop)  rd_ptr_n = rd_ptr_inc;
      fifo_cnt_n = fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // Head as it will stand after this edge, so cmd/data can be loaded on entry to SEND
  always_comb begin
    head_nxt_cmd  = cmd_mem[rd_ptr];
    head_nxt_data = data_mem[rd_ptr];
    if (pop) begin
      if (push && (is_emer || (fifo_cnt == CW'(1)))) begin
        head_nxt_cmd  = req_cmd;
        head_nxt_data = req_data;
      end else begin
        head_nxt_cmd  = cmd_mem[rd_ptr_inc];
        head_nxt_data = data_mem[rd_ptr_inc];
      end
    end else if (fifo_cnt == '0) begin
      head_nxt_cmd  = req_cmd;
      head_nxt_data = req_data;
    end
  end

  // FIFO storage; entries need no reset because fifo_cnt qualifies them
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_addr]  <= req_cmd;
      data_mem[wr_addr] <= req_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
      fifo_cnt <= fifo_cnt_n;
    end
  end

  // Next-state and strobe decode for the request/response handshake
  always_comb begin
    state_n      = state;
    send_cmd     = 1'b0;
    clr_resp_rdy = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    pop          = 1'b0;
    tmo_clr      = 1'b0;
    tmo_run      = 1'b0;
    retry_inc    = 1'b0;
    retry_clr    = 1'b0;
    resp_latch   = 1'b0;
    cause_set    = 1'b0;
    cause_nxt    = cause;
    case (state)
      IDLE: begin
        if ((fifo_cnt != '0) || push) state_n = SEND;
      end
      SEND: begin
        send_cmd = 1'b1;
        tmo_clr  = 1'b1;
        state_n  = WAIT_SENT;
      end
      WAIT_SENT: begin
        tmo_run      = 1'b1;
        clr_resp_rdy = resp_rdy;
        if (cmd_sent) begin
          state_n = WAIT_RESP;
        end else if (tmo_hit) begin
          state_n   = RETRY;
          cause_set = 1'b1;
          cause_nxt = CAUSE_TMO;
        end
      end
      WAIT_RESP: begin
        tmo_run = 1'b1;
        if (resp_rdy) begin
          resp_latch = 1'b1;
          state_n    = LATCH_RESP;
        end else if (tmo_hit) begin
          state_n   = RETRY;
          cause_set = 1'b1;
          cause_nxt = CAUSE_TMO;
        end
      end
      LATCH_RESP: begin
        clr_resp_rdy = 1'b1;
        state_n      = CHECK;
      end
      CHECK: begin
        if (resp_q == ACK_BYTE) begin
          pop       = 1'b1;
          done      = 1'b1;
          retry_clr = 1'b1;
          state_n   = ((fifo_cnt > CW'(1)) || push) ? SEND : IDLE;
        end else begin
          state_n   = RETRY;
          cause_set = 1'b1;
          cause_nxt = CAUSE_BAD;
        end
      end
      RETRY: begin
        if (retry_cnt < RETRY_LIMIT) begin
          retry_inc = 1'b1;
          state_n   = SEND;
        end else begin
          pop       = 1'b1;
          err       = 1'b1;
          retry_clr = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign load_head = (state_n == SEND);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Response timer (saturates at the limit) and retry counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      retry_cnt <= '0;
    end else begin
      if (tmo_clr)                 tmo_cnt <= '0;
      else if (tmo_run && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
      if (retry_clr)      retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + RW'(1);
    end
  end

  // Latched response byte, last failure cause and the reported error code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q   <= '0;
      cause    <= '0;
      err_code <= '0;
    end else begin
      if (resp_latch) resp_q   <= resp;
      if (cause_set)  cause    <= cause_nxt;
      if (err)        err_code <= cause;
    end
  end

  // cmd/data held stable toward RemoteComm for the whole transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd  <= '0;
      data <= '0;
    end else if (load_head) begin
      cmd  <= head_nxt_cmd;
      data <= head_nxt_data;
    end
  end

endmodule

// File: tb/tb_remote_cmd_seq.sv
// tb_remote_cmd_seq: directed bench for remote_cmd_seq with a small RemoteComm
// stub that acknowledges, NAKs, stays silent or never finishes transmitting.
module tb_remote_cmd_seq;

  localparam int RESP_TMO  = 20;
  localparam int MAX_RETRY = 2;
  localparam int DEPTH     = 4;
  localparam int SENT_DLY  = 3;
  localparam int RESP_DLY  = 4;

  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_STUCK  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld;
  logic [7:0]  req_cmd;
  logic [15:0] req_data;
  logic        req_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        clr_resp_rdy;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  fifo_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int stub_mode  = M_NORMAL;
  int stub_nacks = 0;

  int          send_cyc[$];
  logic [7:0]  sent_cmd_log[$];
  logic [15:0] sent_data_log[$];
  int          done_cyc[$];
  int          rise_cyc[$];
  int          clr_cyc[$];
  int          err_cnt = 0;
  logic        resp_rdy_prev = 1'b0;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    int          mode;
    int          nacks;
    int          exp_sends;
    int          exp_done;
    int          exp_err;
    logic [1:0]  exp_code;
    int          exp_gap;
  } vec_t;

  vec_t vecs[7];

  remote_cmd_seq #(
    .RESP_TMO (RESP_TMO),
    .MAX_RETRY(MAX_RETRY),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (req_vld),
    .req_cmd     (req_cmd),
    .req_data    (req_data),
    .req_rdy     (req_rdy),
    .cmd         (cmd),
    .data        (data),
    .send_cmd    (send_cmd),
    .cmd_sent    (cmd_sent),
    .resp_rdy    (resp_rdy),
    .resp        (resp),
    .clr_resp_rdy(clr_resp_rdy),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .fifo_cnt    (fifo_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp observed events
  always @(posedge clk) cyc <= cyc + 1;

  // RemoteComm stub: frame done SENT_DLY cycles after send_cmd, response RESP_DLY later
  int sent_tmr;
  int resp_tmr;
  int attempt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_sent <= 1'b0;
      resp_rdy <= 1'b0;
      resp     <= 8'h00;
      sent_tmr <= 0;
      resp_tmr <= 0;
      attempt  <= 0;
    end else begin
      cmd_sent <= 1'b0;
      if (done || err) attempt <= 0;
      if (send_cmd) begin
        if (stub_mode != M_STUCK) sent_tmr <= SENT_DLY;
      end else if (sent_tmr != 0) begin
        sent_tmr <= sent_tmr - 1;
        if (sent_tmr == 1) begin
          cmd_sent <= 1'b1;
          if (stub_mode == M_NORMAL) resp_tmr <= RESP_DLY;
        end
      end
      if (resp_tmr != 0) begin
        resp_tmr <= resp_tmr - 1;
        if (resp_tmr == 1) begin
          resp_rdy <= 1'b1;
          resp     <= (attempt < stub_nacks) ? 8'hEE : 8'hA5;
          attempt  <= attempt + 1;
        end
      end
      if (clr_resp_rdy) resp_rdy <= 1'b0;
    end
  end

  // Event monitor sampled on the falling edge
  always @(negedge clk) begin
    if (send_cmd) begin
      send_cyc.push_back(cyc);
      sent_cmd_log.push_back(cmd);
      sent_data_log.push_back(data);
    end
    if (done) done_cyc.push_back(cyc);
    if (err) err_cnt++;
    if (clr_resp_rdy) clr_cyc.push_back(cyc);
    if (resp_rdy && !resp_rdy_prev) rise_cyc.push_back(cyc);
    resp_rdy_prev = resp_rdy;
  end

  task automatic applyStimulus(input logic vld, input logic [7:0] c, input logic [15:0] d);
    req_vld  = vld;
    req_cmd  = c;
    req_data = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic pushOne(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    applyStimulus(1'b1, c, d);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 16'h0000);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int sb, db, rb, cb, eb, n;
    logic [7:0]  q_cmd  [4];
    logic [15:0] q_data [4];

    vecs[0] = '{8'h02, 16'h1337, M_NORMAL, 0,  1, 1, 0, 2'b00, 0};
    vecs[1] = '{8'h03, 16'hAAAA, M_NORMAL, 1,  2, 1, 0, 2'b00, 12};
    vecs[2] = '{8'h04, 16'h5555, M_NORMAL, 99, 3, 0, 1, 2'b10, 12};
    vecs[3] = '{8'h05, 16'h00AA, M_SILENT, 0,  3, 0, 1, 2'b01, RESP_TMO + 3};
    vecs[4] = '{8'h06, 16'h0001, M_STUCK,  0,  3, 0, 1, 2'b01, RESP_TMO + 3};
    vecs[5] = '{8'h08, 16'hBEEF, M_NORMAL, 2,  3, 1, 0, 2'b01, 12};
    vecs[6] = '{8'h02, 16'hFFFF, M_NORMAL, 0,  1, 1, 0, 2'b01, 0};

    q_cmd[0] = 8'h03; q_data[0] = 16'hAAAA;
    q_cmd[1] = 8'h04; q_data[1] = 16'h5555;
    q_cmd[2] = 8'h05; q_data[2] = 16'h00AA;
    q_cmd[3] = 8'h02; q_data[3] = 16'h0001;

    $display("[TB] start");
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 16'h0000);
    #12;
    checkOutput("rst_send_cmd", {31'd0, send_cmd}, 0);
    checkOutput("rst_clr_resp_rdy", {31'd0, clr_resp_rdy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_err", {31'd0, err}, 0);
    checkOutput("rst_err_code", {30'd0, err_code}, 0);
    checkOutput("rst_cmd", {24'd0, cmd}, 0);
    checkOutput("rst_data", {16'd0, data}, 0);
    checkOutput("rst_fifo_cnt", {29'd0, fifo_cnt}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_req_rdy", {31'd0, req_rdy}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Push into an empty FIFO: send_cmd must appear in the very next cycle
    sb = send_cyc.size(); db = done_cyc.size();
    applyStimulus(1'b1, 8'h02, 16'h1337);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 16'h0000);
    checkOutput("first_send_cmd", {31'd0, send_cmd}, 1);
    checkOutput("first_cmd", {24'd0, cmd}, 32'h02);
    checkOutput("first_data", {16'd0, data}, 32'h1337);
    checkOutput("first_fifo_cnt", {29'd0, fifo_cnt}, 1);
    waitIdle("first_idle", 400);
    checkOutput("first_sends", send_cyc.size() - sb, 1);
    checkOutput("first_dones", done_cyc.size() - db, 1);
    checkOutput("first_fifo_end", {29'd0, fifo_cnt}, 0);

    // Table-driven single requests under different stub behaviours
    for (int i = 0; i < 7; i++) begin
      stub_mode  = vecs[i].mode;
      stub_nacks = vecs[i].nacks;
      sb = send_cyc.size(); db = done_cyc.size(); eb = err_cnt;
      pushOne(vecs[i].cmd, vecs[i].data);
      waitIdle($sformatf("vec%0d_idle", i), 400);
      checkOutput($sformatf("vec%0d_sends", i), send_cyc.size() - sb, vecs[i].exp_sends);
      checkOutput($sformatf("vec%0d_dones", i), done_cyc.size() - db, vecs[i].exp_done);
      checkOutput($sformatf("vec%0d_errs", i), err_cnt - eb, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d_err_code", i), {30'd0, err_code}, {30'd0, vecs[i].exp_code});
      checkOutput($sformatf("vec%0d_cmd", i), {24'd0, sent_cmd_log[sent_cmd_log.size()-1]}, {24'd0, vecs[i].cmd});
      checkOutput($sformatf("vec%0d_data", i), {16'd0, sent_data_log[sent_data_log.size()-1]}, {16'd0, vecs[i].data});
      checkOutput($sformatf("vec%0d_fifo_cnt", i), {29'd0, fifo_cnt}, 0);
      if (vecs[i].exp_gap != 0 && send_cyc.size() >= sb + vecs[i].exp_sends) begin
        for (int k = 0; k < vecs[i].exp_sends - 1; k++)
          checkOutput($sformatf("vec%0d_gap%0d", i, k), send_cyc[sb+k+1] - send_cyc[sb+k], vecs[i].exp_gap);
      end
    end
    stub_mode  = M_NORMAL;
    stub_nacks = 0;

    // Four back-to-back requests, then a normal push against the full FIFO
    sb = send_cyc.size(); db = done_cyc.size(); rb = rise_cyc.size(); cb = clr_cyc.size();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, q_cmd[i], q_data[i]);
      #1;
      checkOutput($sformatf("b2b_rdy%0d", i), {31'd0, req_rdy}, 1);
      @(negedge clk);
    end
    applyStimulus(1'b1, 8'h02, 16'h1234);
    #1;
    checkOutput("full_fifo_cnt", {29'd0, fifo_cnt}, 4);
    checkOutput("full_req_rdy", {31'd0, req_rdy}, 0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 16'h0000);
    checkOutput("full_no_push", {29'd0, fifo_cnt}, 4);
    waitIdle("b2b_idle", 800);
    checkOutput("b2b_sends", send_cyc.size() - sb, 4);
    checkOutput("b2b_dones", done_cyc.size() - db, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("b2b_cmd%0d", i), {24'd0, sent_cmd_log[sb+i]}, {24'd0, q_cmd[i]});
      checkOutput($sformatf("b2b_data%0d", i), {16'd0, sent_data_log[sb+i]}, {16'd0, q_data[i]});
    end
    checkOutput("ack_clr_timing", clr_cyc[cb] - rise_cyc[rb], 1);
    checkOutput("ack_done_timing", done_cyc[db] - rise_cyc[rb], 2);
    checkOutput("ack_next_send", send_cyc[sb+1] - done_cyc[db], 1);
    checkOutput("b2b_fifo_end", {29'd0, fifo_cnt}, 0);

    // EMER_LAND into a full FIFO while the head is in flight
    sb = send_cyc.size(); db = done_cyc.size();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, q_cmd[i], q_data[i]);
      @(negedge clk);
    end
    applyStimulus(1'b1, 8'h07, 16'h0E0E);
    #1;
    checkOutput("emer_full_cnt", {29'd0, fifo_cnt}, 4);
    checkOutput("emer_full_rdy", {31'd0, req_rdy}, 1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 16'h0000);
    checkOutput("emer_flush_cnt", {29'd0, fifo_cnt}, 2);
    waitIdle("emer_idle", 400);
    checkOutput("emer_sends", send_cyc.size() - sb, 2);
    checkOutput("emer_dones", done_cyc.size() - db, 2);
    checkOutput("emer_head_cmd", {24'd0, sent_cmd_log[sb]}, {24'd0, q_cmd[0]});
    checkOutput("emer_next_cmd", {24'd0, sent_cmd_log[sb+1]}, 32'h07);
    checkOutput("emer_next_data", {16'd0, sent_data_log[sb+1]}, 32'h0E0E);
    checkOutput("emer_fifo_end", {29'd0, fifo_cnt}, 0);

    // EMER_LAND pushed in the same cycle the head retires
    sb = send_cyc.size(); db = done_cyc.size();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, q_cmd[i], q_data[i]);
      @(negedge clk);
    end
    applyStimulus(1'b0, 8'h00, 16'h0000);
    n = 0;
    while (!resp_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ep_resp_seen", {31'd0, resp_rdy}, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ep_done_cycle", {31'd0, done}, 1);
    applyStimulus(1'b1, 8'h07, 16'h7777);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 16'h0000);
    checkOutput("ep_fifo_cnt", {29'd0, fifo_cnt}, 1);
    checkOutput("ep_send_cmd", {31'd0, send_cmd}, 1);
    checkOutput("ep_cmd", {24'd0, cmd}, 32'h07);
    checkOutput("ep_data", {16'd0, data}, 32'h7777);
    waitIdle("ep_idle", 400);
    checkOutput("ep_sends", send_cyc.size() - sb, 2);
    checkOutput("ep_dones", done_cyc.size() - db, 2);
    checkOutput("ep_fifo_end", {29'd0, fifo_cnt}, 0);

    // Reset asserted while waiting for the response
    stub_mode = M_SILENT;
    pushOne(8'h05, 16'h0042);
    n = 0;
    while (!cmd_sent && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst2_cmd_sent_seen", {31'd0, cmd_sent}, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_cmd", {24'd0, cmd}, 0);
    checkOutput("rst2_data", {16'd0, data}, 0);
    checkOutput("rst2_fifo_cnt", {29'd0, fifo_cnt}, 0);
    checkOutput("rst2_busy", {31'd0, busy}, 0);
    checkOutput("rst2_err_code", {30'd0, err_code}, 0);
    checkOutput("rst2_req_rdy", {31'd0, req_rdy}, 1);
    sb = send_cyc.size(); db = done_cyc.size(); eb = err_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stub_mode = M_NORMAL;
    repeat (30) @(negedge clk);
    checkOutput("rst2_no_send", send_cyc.size() - sb, 0);
    checkOutput("rst2_no_done", done_cyc.size() - db, 0);
    checkOutput("rst2_no_err", err_cnt - eb, 0);
    checkOutput("rst2_req_rdy_after", {31'd0, req_rdy}, 1);
    checkOutput("rst2_busy_after", {31'd0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
